led_display_scheduler: RTL and testbench
========================================

Name: led_display_scheduler

Overview:
- Shares the 6x6 LED array between NUM_REQ independent requesters (compute status, error flags, debug, heartbeat).
- Sits directly upstream of the LED driver and produces its enable, load strobe and 36-bit frame.
- Round-robin arbitration; each granted frame is held for a fixed dwell time, then the next pending requester is served.
- Array is blanked when no requester is active or display is disabled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LED_W, 36, frame width, one bit per LED, 1 = LED lit.
- HOLD_CYCLES, 50000000, dwell time per grant in clk cycles (>=1); counter width $clog2(HOLD_CYCLES+1).

Ports:
- clk  input  1  system clock.
- rst_l  input  1  asynchronous active-low reset.
- disp_en  input  1  global display enable; low forces blank and idle.
- req  input  NUM_REQ  per-requester level request, held high while the requester wants display time.
- req_data  input  NUM_REQ*LED_W  flattened frames; requester i occupies bits [i*LED_W +: LED_W].
- gnt  output  NUM_REQ  one-hot, one-cycle pulse marking the cycle requester i's frame is loaded.
- active_id  output  $clog2(NUM_REQ)  index of the requester currently displayed.
- busy  output  1  high in ARB and HOLD.
- led_en  output  1  enable to the LED driver.
- led_data_ld  output  1  one-cycle load strobe to the LED driver.
- led_data  output  LED_W  frame to the LED driver, active-high.

Behaviour:
- All outputs are registered.
- Reset (async, rst_l low) values:
  - state = IDLE.
  - led_en, led_data_ld, busy, gnt = 0.
  - led_data = 0, active_id = 0, hold counter = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, ARB, HOLD.
- IDLE:
  - led_en = 0 (array blank).
  - If disp_en && |req, go to ARB next edge; otherwise stay.
- ARB (one cycle):
  - If no req is high, go to IDLE and set led_en <= 0.
  - Otherwise the winner w is the first requester with req high, searching last+1, last+2, ... modulo NUM_REQ.
  - On the exit edge: led_data <= req_data[w], led_data_ld <= 1, led_en <= 1, gnt <= onehot(w), active_id <= w, last <= w, counter <= HOLD_CYCLES-1, state <= HOLD.
- HOLD:
  - led_data_ld and gnt are 0 after the first HOLD cycle, so each is exactly a one-cycle pulse.
  - led_en stays 1 and led_data is frozen; changes on req_data during HOLD are ignored.
  - Counter decrements once per cycle.
  - When counter == 0, go to ARB. Total dwell from the load-strobe cycle to ARB entry is HOLD_CYCLES cycles.
  - Early release: if req[active_id] drops during HOLD, go to ARB next edge and ignore the counter.
- Latency: a req rising while IDLE produces led_data_ld/gnt 2 cycles later (IDLE->ARB->HOLD).
- Continuous single requester: re-granted every HOLD_CYCLES+1 cycles, with fresh data loaded each time. led_en never drops between back-to-back grants.
- Fairness: with all requests asserted, the grant order is 0,1,..,NUM_REQ-1,0,... Requests that are not high in ARB are skipped.
- disp_en low in any state:
  - Next edge: state <= IDLE, led_en <= 0, led_data_ld <= 0, gnt <= 0.
  - led_data and last are retained.
  - disp_en low takes priority over every other transition.
- Simultaneous HOLD expiry and active-req drop: a single transition to ARB.
- Reset asserted mid-HOLD: immediate return to reset values (blank); no pending grant survives.
- busy = (state != IDLE), registered.

Test Plan (HOLD_CYCLES=4, NUM_REQ=4):
- Reset, disp_en=1, req=0000 for 10 cycles -> led_en=0, gnt=0, busy=0 throughout.
- req=0001, data0=36'h0_0000_0FFF held high -> led_data_ld and gnt=0001 pulse once at cycle +2 with led_data=36'h0000_0FFF, led_en=1. Re-pulse every 5 cycles.
- req=1111, distinct data per requester -> gnt sequence 0001,0010,0100,1000,0001, each exactly 5 cycles apart. active_id follows 0,1,2,3,0.
- Active requester 2 drops req one cycle after its grant while req3 is pending -> next edge ARB, gnt=1000 two cycles after the drop, without waiting for dwell expiry.
- disp_en deasserted mid-HOLD -> led_en=0 on next edge, state IDLE. Re-assert with req=0100 -> requester 2 granted 2 cycles later, after the round-robin pointer retained from before the disable.
- rst_l pulsed low mid-HOLD (asynchronously, between edges) -> led_en, busy, gnt drop to 0 immediately. After release, requester 0 wins first when all requests are high.

Source files
------------

// File: rtl/led_display_scheduler.sv
// Round-robin scheduler sharing a single LED frame driver between NUM_REQ requesters.
// Each granted frame is latched and held for HOLD_CYCLES cycles, or released early when its requester drops.
module led_display_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LED_W       = 36,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       disp_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       led_en,
  output logic                       led_data_ld,
  output logic [LED_W-1:0]           led_data
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_RST    = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic               ld_q, ld_d;
  logic [LED_W-1:0]   data_q, data_d;

  logic [LED_W-1:0]   frames [NUM_REQ];
  logic               win_found;
  logic [IDW-1:0]     win_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_frames
    assign frames[g] = req_data[g*LED_W +: LED_W];
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    logic [IDW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt_d   = '0;
    en_d    = en_q;
    ld_d    = 1'b0;
    data_d  = data_q;

    if (!disp_en) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          en_d = 1'b0;
          if (|req) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (!win_found) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end else begin
            state_d        = ST_HOLD;
            data_d         = frames[win_idx];
            ld_d           = 1'b1;
            en_d           = 1'b1;
            gnt_d[win_idx] = 1'b1;
            id_d           = win_idx;
            last_d         = win_idx;
            cnt_d          = HOLD_RELOAD;
          end
        end
        ST_HOLD: begin
          en_d = 1'b1;
          if (cnt_q == '0 || !req[id_q]) begin
            state_d = ST_ARB;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      id_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      data_q  <= data_d;
    end
  end

  assign gnt         = gnt_q;
  assign active_id   = id_q;
  assign busy        = busy_q;
  assign led_en      = en_q;
  assign led_data_ld = ld_q;
  assign led_data    = data_q;

endmodule

// File: tb/tb_led_display_scheduler.sv
// Directed and randomized checks of led_display_scheduler against a transaction-level display model.
module tb_led_display_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 36;
  localparam int unsigned H = 4;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             disp_en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic [1:0]       active_id;
  logic             busy;
  logic             led_en;
  logic             led_data_ld;
  logic [W-1:0]     led_data;

  int checks = 0;
  int errors = 0;

  // Model: "showing" a frame for m_shown cycles, or waiting to pick one.
  bit           m_en, m_ld, m_busy, m_showing, m_pick;
  logic [N-1:0] m_gnt;
  int unsigned  m_id, m_last, m_shown;
  logic [W-1:0] m_data;

  led_display_scheduler #(.NUM_REQ(N), .LED_W(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_l(rst_l), .disp_en(disp_en), .req(req), .req_data(req_data),
    .gnt(gnt), .active_id(active_id), .busy(busy), .led_en(led_en),
    .led_data_ld(led_data_ld), .led_data(led_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ld = 0; m_busy = 0; m_showing = 0; m_pick = 0;
    m_gnt = '0; m_id = 0; m_last = N - 1; m_shown = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit found;
    if (!rst_l) begin
      model_reset();
    end else if (!disp_en) begin
      m_showing = 0; m_pick = 0; m_en = 0; m_ld = 0; m_gnt = '0; m_busy = 0;
    end else if (m_pick) begin
      m_pick = 0;
      m_ld = 0; m_gnt = '0;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found = 1;
          m_id = c; m_last = c;
          m_data = req_data[c*W +: W];
          m_gnt = '0; m_gnt[c] = 1'b1;
          m_ld = 1; m_en = 1; m_busy = 1;
          m_showing = 1; m_shown = 1;
        end
      end
      if (!found) begin
        m_en = 0; m_busy = 0;
      end
    end else if (m_showing) begin
      m_ld = 0; m_gnt = '0;
      if (m_shown == H || !req[m_id]) begin
        m_showing = 0; m_pick = 1;
      end else begin
        m_shown++;
      end
    end else begin
      m_ld = 0; m_gnt = '0; m_en = 0;
      if (req != '0) begin
        m_pick = 1; m_busy = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("led_en", led_en, m_en);
    chk("led_data_ld", led_data_ld, m_ld);
    chk("gnt", gnt, m_gnt);
    chk("busy", busy, m_busy);
    chk("active_id", active_id, m_id);
    chk("led_data", led_data, m_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_frames();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 36'h1_1111_1111 * (i + 1);
  endtask

  initial begin
    int unsigned exp_ids [4] = '{1, 2, 3, 0};
    logic [N-1:0] e_gnt;
    logic [63:0]  r;

    rst_l = 1'b0; disp_en = 1'b1; req = '0; req_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    check_model();
    repeat (10) tick();

    // Single requester: latency 2, re-grant every H+1 cycles
    req = 4'b0001;
    req_data[0 +: W] = 36'h0_0000_0FFF;
    tick();
    chk("t2_arb_ld", led_data_ld, 1'b0);
    chk("t2_arb_busy", busy, 1'b1);
    tick();
    chk("t2_gnt", gnt, 4'b0001);
    chk("t2_ld", led_data_ld, 1'b1);
    chk("t2_en", led_en, 1'b1);
    chk("t2_data", led_data, 36'h0_0000_0FFF);
    repeat (4) tick();
    tick();
    chk("t2_regrant", gnt, 4'b0001);

    // All requesting: strict rotation, 5 cycles apart
    req = 4'b1111;
    set_frames();
    for (int k = 0; k < 4; k++) begin
      repeat (4) begin
        tick();
        chk("t3_gap", gnt, 4'b0000);
      end
      tick();
      e_gnt = 4'b0001 << exp_ids[k];
      chk("t3_gnt", gnt, e_gnt);
      chk("t3_id", active_id, exp_ids[k]);
      chk("t3_data", led_data, 36'h1_1111_1111 * (exp_ids[k] + 1));
    end

    // Early release by requester 2 while 3 is pending
    repeat (5) tick();
    chk("t4_gnt1", gnt, 4'b0010);
    repeat (5) tick();
    chk("t4_gnt2", gnt, 4'b0100);
    tick();
    req = 4'b1000;
    tick();
    chk("t4_arb_ld", led_data_ld, 1'b0);
    chk("t4_arb_en", led_en, 1'b1);
    tick();
    chk("t4_gnt3", gnt, 4'b1000);
    chk("t4_id", active_id, 3);
    chk("t4_data", led_data, 36'h4_4444_4444);

    // Display disable mid-hold, then re-enable with only requester 2
    tick();
    disp_en = 1'b0;
    tick();
    chk("t5_en_off", led_en, 1'b0);
    chk("t5_busy_off", busy, 1'b0);
    chk("t5_data_kept", led_data, 36'h4_4444_4444);
    tick();
    disp_en = 1'b1;
    req = 4'b0100;
    tick();
    chk("t5_arb_ld", led_data_ld, 1'b0);
    tick();
    chk("t5_gnt", gnt, 4'b0100);
    chk("t5_id", active_id, 2);

    // Asynchronous reset between edges during the grant cycle
    #1 rst_l = 1'b0;
    #1 model_reset();
    chk("t6_en", led_en, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_gnt", gnt, 4'b0000);
    chk("t6_data", led_data, 36'h0);
    @(negedge clk);
    rst_l = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    chk("t6_first", gnt, 4'b0001);
    chk("t6_first_id", active_id, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        r = {$urandom(), $urandom()};
        req_data[i*W +: W] = r[W-1:0];
      end
      disp_en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_l = 1'b0;
        #1 model_reset();
        check_model();
        #1 rst_l = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
